scoreboard_hazard_unit: RTL

Parametrised successor to the fixed-table hazard/stall logic. It tracks every in-flight register write with a per-register remaining-latency counter, plus a write-back slot reservation vector. Dependent instructions stall only as long as needed, and independent instructions overlap with long FPU ops instead of freezing the whole pipe. It sits beside the decode stage and drives StallF/StallD/FlushE. Forwarding mux selects stay in the existing forwarding logic.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/scoreboard_hazard_unit_if.sv | 33 +++
 rtl/scoreboard_hazard_unit_latency_scoreboard.sv | 48 ++++
 rtl/scoreboard_hazard_unit.sv | 94 +++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared parameters, per-op producer latencies and the hazard flag bundle
// used by the scoreboard hazard unit and the decoder.
package hazard_pkg;

  localparam int REG_W   = 6;
  localparam int LAT_W   = 4;
  localparam int MAX_LAT = 8;
  localparam int FWD_LAT = 1;

  localparam logic [LAT_W-1:0] LAT_ALU   = 4'd1;
  localparam logic [LAT_W-1:0] LAT_LW    = 4'd2;
  localparam logic [LAT_W-1:0] LAT_FADD  = 4'd4;
  localparam logic [LAT_W-1:0] LAT_FSUB  = 4'd4;
  localparam logic [LAT_W-1:0] LAT_FMUL  = 4'd3;
  localparam logic [LAT_W-1:0] LAT_FDIV  = 4'd6;
  localparam logic [LAT_W-1:0] LAT_FSQRT = 4'd3;
  localparam logic [LAT_W-1:0] LAT_FCVT  = 4'd2;
  localparam logic [LAT_W-1:0] LAT_FMOV  = 4'd1;

  typedef struct packed {
    logic raw;
    logic waw;
    logic wbc;
    logic inst;
  } hazard_t;

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// Decode-stage view of the hazard unit: D instruction fields in, stall
// controls and the idle indication out.
interface scoreboard_hazard_unit_if #(
  parameter int REG_W = 6,
  parameter int LAT_W = 4
);
  logic             IssueD;
  logic [REG_W-1:0] RsD;
  logic [REG_W-1:0] RtD;
  logic             UseRsD;
  logic             UseRtD;
  logic             RegWriteD;
  logic [REG_W-1:0] WriteRegD;
  logic [LAT_W-1:0] LatD;
  logic             InD;
  logic             Rx_ready;
  logic             StallF;
  logic             StallD;
  logic             FlushE;
  logic             Idle;

  modport master (
    output IssueD, RsD, RtD, UseRsD, UseRtD, RegWriteD, WriteRegD, LatD,
           InD, Rx_ready,
    input  StallF, StallD, FlushE, Idle
  );

  modport slave (
    input  IssueD, RsD, RtD, UseRsD, UseRtD, RegWriteD, WriteRegD, LatD,
           InD, Rx_ready,
    output StallF, StallD, FlushE, Idle
  );
endinterface

// File: rtl/scoreboard_hazard_unit_latency_scoreboard.sv
// Per-register remaining-latency counters with three read ports.
// A load wins over the decrement of the same register in the same cycle.
module latency_scoreboard #(
  parameter int REG_W = 6,
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_en,
  input  logic [REG_W-1:0] load_idx,
  input  logic [LAT_W-1:0] load_val,
  input  logic [REG_W-1:0] rs_idx,
  input  logic [REG_W-1:0] rt_idx,
  input  logic [REG_W-1:0] wr_idx,
  output logic [LAT_W-1:0] rs_cnt,
  output logic [LAT_W-1:0] rt_cnt,
  output logic [LAT_W-1:0] wr_cnt,
  output logic             all_zero
);
  localparam int N_REGS = 2 ** REG_W;

  logic [LAT_W-1:0]  cnt_r [N_REGS];
  logic [N_REGS-1:0] busy_s;

  // Counter array: reload on accepted write, otherwise drain towards zero
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REGS; i++) begin
      if (!rstn) begin
        cnt_r[i] <= '0;
      end else if (load_en && (load_idx == REG_W'(i))) begin
        cnt_r[i] <= load_val;
      end else if (cnt_r[i] != '0) begin
        cnt_r[i] <= cnt_r[i] - LAT_W'(1);
      end else begin
        cnt_r[i] <= '0;
      end
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_busy
    assign busy_s[g] = |cnt_r[g];
  end

  assign rs_cnt   = cnt_r[rs_idx];
  assign rt_cnt   = cnt_r[rt_idx];
  assign wr_cnt   = cnt_r[wr_idx];
  assign all_zero = ~|busy_s;
endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard hazard unit: stalls a D instruction only while a source, its
// destination or its write-back slot is still owned by an in-flight producer.
module scoreboard_hazard_unit #(
  parameter int REG_W   = hazard_pkg::REG_W,
  parameter int LAT_W   = hazard_pkg::LAT_W,
  parameter int MAX_LAT = hazard_pkg::MAX_LAT,
  parameter int FWD_LAT = hazard_pkg::FWD_LAT
) (
  input logic                    clk,
  input logic                    rstn,
  scoreboard_hazard_unit_if.slave hz
);
  import hazard_pkg::*;

  localparam int WB_W = MAX_LAT + 1;

  logic [LAT_W-1:0] lat_eff_s;
  logic [LAT_W-1:0] rs_cnt_s;
  logic [LAT_W-1:0] rt_cnt_s;
  logic [LAT_W-1:0] wr_cnt_s;
  logic             all_zero_s;
  logic [WB_W-1:0]  wb_r;
  logic [WB_W-1:0]  wb_pick_s;
  logic [WB_W-1:0]  wb_set_s;
  hazard_t          haz_s;
  logic             stall_s;
  logic             acc_s;

  // Out-of-range latencies are clamped rather than rejected
  always_comb begin
    lat_eff_s = hz.LatD;
    if (hz.LatD == '0) begin
      lat_eff_s = LAT_W'(1);
    end else if (hz.LatD > LAT_W'(MAX_LAT)) begin
      lat_eff_s = LAT_W'(MAX_LAT);
    end else begin
      lat_eff_s = hz.LatD;
    end
  end

  // Hazard detection and issue acceptance from current state and D fields
  always_comb begin
    wb_pick_s  = wb_r >> lat_eff_s;
    haz_s.raw  = (hz.UseRsD && (hz.RsD != '0) && (rs_cnt_s > LAT_W'(FWD_LAT))) ||
                 (hz.UseRtD && (hz.RtD != '0) && (rt_cnt_s > LAT_W'(FWD_LAT)));
    haz_s.waw  = hz.RegWriteD && (hz.WriteRegD != '0) && (wr_cnt_s > lat_eff_s);
    haz_s.wbc  = hz.RegWriteD && wb_pick_s[0];
    haz_s.inst = hz.InD && !hz.Rx_ready;
    stall_s    = rstn && hz.IssueD && (|haz_s);
    acc_s      = rstn && hz.IssueD && !stall_s && hz.RegWriteD && (hz.WriteRegD != '0);
  end

  // Write-back reservation for a newly accepted producer
  always_comb begin
    wb_set_s = '0;
    if (acc_s) begin
      wb_set_s = WB_W'(1'b1) << (lat_eff_s - LAT_W'(1));
    end else begin
      wb_set_s = '0;
    end
  end

  // Slot vector advances one retire position per cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wb_r <= '0;
    end else begin
      wb_r <= (wb_r >> 1) | wb_set_s;
    end
  end

  latency_scoreboard #(
    .REG_W (REG_W),
    .LAT_W (LAT_W)
  ) u_scoreboard (
    .clk      (clk),
    .rstn     (rstn),
    .load_en  (acc_s),
    .load_idx (hz.WriteRegD),
    .load_val (lat_eff_s),
    .rs_idx   (hz.RsD),
    .rt_idx   (hz.RtD),
    .wr_idx   (hz.WriteRegD),
    .rs_cnt   (rs_cnt_s),
    .rt_cnt   (rt_cnt_s),
    .wr_cnt   (wr_cnt_s),
    .all_zero (all_zero_s)
  );

  assign hz.StallF = stall_s;
  assign hz.StallD = stall_s;
  assign hz.FlushE = stall_s;
  assign hz.Idle   = !rstn || (all_zero_s && (wb_r == '0));
endmodule
